// File: rtl/xeng_pkg.sv
// Shared X-engine definitions: bank-select constants and a constant-foldable log2
// used to size antenna address fields.
package xeng_pkg;

  localparam logic BANK0 = 1'b0;
  localparam logic BANK1 = 1'b1;

  // Ceiling log2; evaluated at elaboration to derive ANT_BITS from N_ANTS.
  function automatic int log2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/xeng_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read-first read port.
// Array contents are never reset; only the read register clears on rst.
module xeng_sdp_ram
  import xeng_pkg::*;
#(
  parameter int ADDR_BITS  = 5,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_we,
  input  logic [ADDR_BITS-1:0]  i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [ADDR_BITS-1:0]  i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];
  logic [DATA_WIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Same-edge read sees the pre-write contents (read-first).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_rdata <= '0;
    else     r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/xeng_ant_dbuf.sv
// Double-buffered antenna sample store feeding the baseline-order generator.
// Optional sticky bank-collision detector built when XENG_ANT_DBUF_COLLIDE_EN is defined.
module xeng_ant_dbuf
  import xeng_pkg::*;
#(
  parameter  int N_ANTS     = 16,
  parameter  int DATA_WIDTH = 16,
  localparam int ANT_BITS   = log2(N_ANTS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sync_in,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_vld,
  input  logic [ANT_BITS-1:0]   rd_ant_a,
  input  logic [ANT_BITS-1:0]   rd_ant_b,
  input  logic                  rd_buf_sel,
  output logic [DATA_WIDTH-1:0] dout_a,
  output logic [DATA_WIDTH-1:0] dout_b,
  output logic                  frame_rdy,
  output logic                  frame_bank,
  output logic                  collide
);

  localparam logic [ANT_BITS-1:0] CNT_LAST = ANT_BITS'(N_ANTS - 1);

  logic [ANT_BITS-1:0]   r_wr_cnt;
  logic                  r_wr_bank;
  logic                  r_frame_rdy;
  logic                  r_frame_bank;

  logic [ANT_BITS-1:0]   w_cnt_eff;
  logic                  w_bank_eff;
  logic                  w_last;
  logic [ANT_BITS:0]     w_waddr;
  logic [ANT_BITS-1:0]   w_rd_ant [2];
  logic [DATA_WIDTH-1:0] w_rdata  [2];

  // sync_in restarts the frame in the same cycle, so a qualified sample lands at bank 0, address 0.
  assign w_cnt_eff  = sync_in ? '0 : r_wr_cnt;
  assign w_bank_eff = sync_in ? BANK0 : r_wr_bank;
  assign w_last     = din_vld && (w_cnt_eff == CNT_LAST);
  assign w_waddr    = {w_bank_eff, w_cnt_eff};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_cnt     <= '0;
      r_wr_bank    <= BANK0;
      r_frame_rdy  <= 1'b0;
      r_frame_bank <= BANK0;
    end else begin
      r_frame_rdy <= w_last;
      if (w_last) r_frame_bank <= w_bank_eff;
      if (din_vld) begin
        r_wr_cnt  <= w_cnt_eff + ANT_BITS'(1);
        r_wr_bank <= w_last ? ~w_bank_eff : w_bank_eff;
      end else begin
        r_wr_cnt  <= w_cnt_eff;
        r_wr_bank <= w_bank_eff;
      end
    end
  end

  assign frame_rdy  = r_frame_rdy;
  assign frame_bank = r_frame_bank;

  assign w_rd_ant[0] = rd_ant_a;
  assign w_rd_ant[1] = rd_ant_b;

  // One RAM copy per read port; both see identical writes.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rport
      xeng_sdp_ram #(
        .ADDR_BITS  (ANT_BITS + 1),
        .DATA_WIDTH (DATA_WIDTH)
      ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .i_we    (din_vld),
        .i_waddr (w_waddr),
        .i_wdata (din),
        .i_raddr ({rd_buf_sel, w_rd_ant[gi]}),
        .o_rdata (w_rdata[gi])
      );
    end
  endgenerate

  assign dout_a = w_rdata[0];
  assign dout_b = w_rdata[1];

`ifdef XENG_ANT_DBUF_COLLIDE_EN
  logic r_collide;

  // Sticky until rst: reader selected the bank being written this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                    r_collide <= 1'b0;
    else if (din_vld && (rd_buf_sel == w_bank_eff)) r_collide <= 1'b1;
  end

  assign collide = r_collide;
`else
  assign collide = 1'b0;
`endif

endmodule

// File: tb/tb_xeng_ant_dbuf.sv
// Scoreboard bench for xeng_ant_dbuf: stimulus pushes expected reads and frame
// events into queues; negedge monitors pop and compare.
module tb_xeng_ant_dbuf;

  localparam int N_ANTS = 16;
  localparam int DW     = 16;
  localparam int AB     = 4;

  logic          clk;
  logic          rst;
  logic          sync_in;
  logic [DW-1:0] din;
  logic          din_vld;
  logic [AB-1:0] rd_ant_a;
  logic [AB-1:0] rd_ant_b;
  logic          rd_buf_sel;
  logic [DW-1:0] dout_a;
  logic [DW-1:0] dout_b;
  logic          frame_rdy;
  logic          frame_bank;
  logic          collide;

  int checks = 0;
  int errors = 0;
  int cycle_cnt = 0;
  logic rd_chk = 1'b0;
  logic rd_chk_d = 1'b0;
  logic [31:0] rd_q [$];
  logic [32:0] fr_q [$];

`ifdef XENG_ANT_DBUF_COLLIDE_EN
  localparam logic COLL_EXP = 1'b1;
`else
  localparam logic COLL_EXP = 1'b0;
`endif

  xeng_ant_dbuf #(.N_ANTS(N_ANTS), .DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .sync_in    (sync_in),
    .din        (din),
    .din_vld    (din_vld),
    .rd_ant_a   (rd_ant_a),
    .rd_ant_b   (rd_ant_b),
    .rd_buf_sel (rd_buf_sel),
    .dout_a     (dout_a),
    .dout_b     (dout_b),
    .frame_rdy  (frame_rdy),
    .frame_bank (frame_bank),
    .collide    (collide)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cycle_cnt <= cycle_cnt + 1;
    rd_chk_d  <= rd_chk;
  end

  // Read-data monitor
  always @(negedge clk) begin
    if (rd_chk_d) begin
      logic [31:0] e;
      checks++;
      if (rd_q.size() == 0) begin
        errors++;
        $display("FAIL rd_data: result with empty scoreboard, got %h/%h", dout_a, dout_b);
      end else begin
        e = rd_q.pop_front();
        if ({dout_a, dout_b} !== e) begin
          errors++;
          $display("FAIL rd_data: got a=%h b=%h expected a=%h b=%h", dout_a, dout_b, e[31:16], e[15:0]);
        end else
          $display("read a=%h b=%h ok", dout_a, dout_b);
      end
    end
  end

  // Frame-ready monitor: checks both the cycle and the bank of each pulse
  always @(negedge clk) begin
    if (!rst && frame_rdy) begin
      logic [32:0] e;
      checks++;
      if (fr_q.size() == 0) begin
        errors++;
        $display("FAIL frame_rdy: unexpected pulse at cycle %0d, bank %0d", cycle_cnt, frame_bank);
      end else begin
        e = fr_q.pop_front();
        if (cycle_cnt != int'(e[31:0]) || frame_bank !== e[32]) begin
          errors++;
          $display("FAIL frame_rdy: got cycle %0d bank %0d expected cycle %0d bank %0d",
                   cycle_cnt, frame_bank, e[31:0], e[32]);
        end else
          $display("frame_rdy cycle %0d bank %0d ok", cycle_cnt, frame_bank);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else
      $display("%s = %h ok", name, act);
  endtask

  task automatic wr(input logic [DW-1:0] d, input logic s);
    din = d; din_vld = 1'b1; sync_in = s;
    cyc();
    din_vld = 1'b0; sync_in = 1'b0;
  endtask

  task automatic rd(input logic [AB-1:0] a, input logic [AB-1:0] b, input logic sel,
                    input logic [DW-1:0] ea, input logic [DW-1:0] eb);
    rd_ant_a = a; rd_ant_b = b; rd_buf_sel = sel; rd_chk = 1'b1;
    rd_q.push_back({ea, eb});
    cyc();
    rd_chk = 1'b0;
  endtask

  task automatic exp_frame(input logic bank);
    fr_q.push_back({bank, 32'(cycle_cnt)});
  endtask

  initial begin
    rst = 1'b1; sync_in = 1'b0; din = '0; din_vld = 1'b0;
    rd_ant_a = '0; rd_ant_b = '0; rd_buf_sel = 1'b1;
    cyc(); cyc();
    chk("rst_dout_a", 32'(dout_a), 32'h0);
    chk("rst_dout_b", 32'(dout_b), 32'h0);
    chk("rst_frame_rdy", 32'(frame_rdy), 32'h0);
    chk("rst_frame_bank", 32'(frame_bank), 32'h0);
    chk("rst_collide", 32'(collide), 32'h0);
    rst = 1'b0;
    cyc();

    // Frame 1 into bank 0
    rd_buf_sel = 1'b1;
    for (int i = 0; i < 16; i++) wr(16'h0100 + 16'(i), i == 0);
    exp_frame(1'b0);
    rd(4'd15, 4'd0, 1'b0, 16'h010F, 16'h0100);
    rd(4'd3, 4'd9, 1'b0, 16'h0103, 16'h0109);

    // Frame 2 into bank 1; bank 0 untouched
    rd_buf_sel = 1'b0;
    for (int i = 0; i < 16; i++) wr(16'h0200 + 16'(i), 1'b0);
    exp_frame(1'b1);
    rd(4'd5, 4'd15, 1'b1, 16'h0205, 16'h020F);
    rd(4'd3, 4'd9, 1'b0, 16'h0103, 16'h0109);

    // Partial frame discarded by sync_in coinciding with a write
    rd_buf_sel = 1'b1;
    for (int i = 0; i < 7; i++) wr(16'h0300 + 16'(i), 1'b0);
    wr(16'h03AA, 1'b1);
    for (int i = 1; i < 16; i++) wr(16'h0400 + 16'(i), 1'b0);
    exp_frame(1'b0);
    rd(4'd0, 4'd6, 1'b0, 16'h03AA, 16'h0406);
    rd(4'd15, 4'd7, 1'b0, 16'h040F, 16'h0407);

    // Gapped writes into bank 1: 32 cycles per frame
    rd_buf_sel = 1'b0;
    for (int i = 0; i < 16; i++) begin
      wr(16'h0500 + 16'(i), 1'b0);
      if (i == 15) exp_frame(1'b1);
      cyc();
    end
    rd(4'd7, 4'd12, 1'b1, 16'h0507, 16'h050C);
    chk("no_collide_yet", 32'(collide), 32'h0);

    // Collision: reading bank 0 while bank 0 is written
    rd_buf_sel = 1'b0;
    wr(16'h0600, 1'b0);
    rd_buf_sel = 1'b1;
    chk("collide_set", 32'(collide), 32'(COLL_EXP));
    wr(16'h0601, 1'b1);
    cyc(); cyc();
    chk("collide_after_sync", 32'(collide), 32'(COLL_EXP));

    // Async reset mid-frame at write 10
    rd_ant_a = 4'd7; rd_ant_b = 4'd12; rd_buf_sel = 1'b1;
    for (int i = 2; i < 10; i++) wr(16'h0700 + 16'(i), 1'b0);
    chk("pre_rst_dout_a", 32'(dout_a), 32'h0507);
    din = 16'h07FF; din_vld = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("midrst_dout_a", 32'(dout_a), 32'h0);
    chk("midrst_dout_b", 32'(dout_b), 32'h0);
    chk("midrst_frame_bank", 32'(frame_bank), 32'h0);
    chk("midrst_collide", 32'(collide), 32'h0);
    din_vld = 1'b0;
    cyc();
    rst = 1'b0;
    cyc();
    rd_buf_sel = 1'b1;
    for (int i = 0; i < 16; i++) wr(16'h0800 + 16'(i), 1'b0);
    exp_frame(1'b0);
    rd(4'd0, 4'd15, 1'b0, 16'h0800, 16'h080F);
    chk("post_rst_collide", 32'(collide), 32'h0);

    cyc(); cyc(); cyc();
    chk("frames_pending", 32'(fr_q.size()), 32'h0);
    chk("reads_pending", 32'(rd_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
